// File: rtl/rf_debug_port.sv
// rf_debug_port: debug-side initiator for the CPU register file.
// Takes one read/write command at a time over cmd_valid/cmd_ready, drives the
// register file ports, and returns one response over resp_valid/resp_ready.
// Optional feature macro: RF_DBG_CLEAR_EN. When it is defined, cmd_clear
// zeroes x0 .. x(NREGS-1) with one write per cycle.
module rf_debug_port #(
   parameter int NREGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic        cmd_clear,
   input  logic [4:0]  cmd_index,
   input  logic [31:0] cmd_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_write,
   output logic [4:0]  resp_index,
   output logic [31:0] resp_rdata,
   output logic        reg_write,
   output logic [4:0]  write_index,
   output logic [31:0] write_data,
   output logic [4:0]  read_index1,
   output logic [4:0]  read_index2,
   input  logic [31:0] read_data1,
   input  logic [31:0] read_data2
);

`ifdef RF_DBG_CLEAR_EN
   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CLR, S_RESP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RESP} state_t;
`endif

   // Last index touched by a clear-all walk.
   localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

   state_t      state_q, state_d;
   logic        write_q, write_d;   // response kind: write/clear ack vs read
   logic [4:0]  index_q, index_d;   // latched command index, later resp_index
   logic [31:0] data_q,  data_d;    // write data, then read capture / response data
`ifdef RF_DBG_CLEAR_EN
   logic [4:0]  cnt_q,   cnt_d;     // clear-all walk position
`endif

   // Port 2 of the register file is not used by the debug path.
   assign read_index2 = 5'd0;

   // Inputs that are deliberately unused in some builds are collected here.
   logic unused_inputs;
   assign unused_inputs = ^{read_data2, cmd_clear, LAST_IDX};

   // Next-state, latch updates and Moore-style output decode.
   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      index_d     = index_q;
      data_d      = data_q;
`ifdef RF_DBG_CLEAR_EN
      cnt_d       = cnt_q;
`endif
      cmd_ready   = 1'b0;
      resp_valid  = 1'b0;
      resp_write  = 1'b0;
      resp_index  = 5'd0;
      resp_rdata  = 32'd0;
      reg_write   = 1'b0;
      write_index = 5'd0;
      write_data  = 32'd0;
      read_index1 = 5'd0;
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               write_d = cmd_write;
               index_d = cmd_index;
               data_d  = cmd_wdata;
`ifdef RF_DBG_CLEAR_EN
               // Clear wins over write when both are requested.
               if (cmd_clear) begin
                  state_d = S_CLR;
                  cnt_d   = 5'd0;
               end else if (cmd_write) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
`else
               if (cmd_write) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WR: begin
            reg_write   = 1'b1;
            write_index = index_q;
            write_data  = data_q;
            state_d     = S_RESP;
         end
         S_RD: begin
            // Register file read is combinational; capture at the end of this cycle.
            read_index1 = index_q;
            data_d      = read_data1;
            state_d     = S_RESP;
         end
`ifdef RF_DBG_CLEAR_EN
         S_CLR: begin
            reg_write   = 1'b1;
            write_index = cnt_q;
            write_data  = 32'd0;
            if (cnt_q == LAST_IDX) begin
               state_d = S_RESP;
               write_d = 1'b1;
               index_d = LAST_IDX;
               data_d  = 32'd0;
               cnt_d   = 5'd0;
            end else begin
               cnt_d   = cnt_q + 5'd1;
            end
         end
`endif
         S_RESP: begin
            resp_valid = 1'b1;
            resp_write = write_q;
            resp_index = index_q;
            resp_rdata = data_q;
            if (resp_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and latch registers with synchronous reset; a reset drops any pending response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         write_q <= 1'b0;
         index_q <= 5'd0;
         data_q  <= 32'd0;
`ifdef RF_DBG_CLEAR_EN
         cnt_q   <= 5'd0;
`endif
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         index_q <= index_d;
         data_q  <= data_d;
`ifdef RF_DBG_CLEAR_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

endmodule
